// File: rtl/pipe_skid_reg.sv
// Two-entry skid pipeline register (main + skid) with multi-source stall,
// flush with optional data clearing, and a saturating flush counter.
// in_ready depends only on registered state and the stall inputs, so no
// combinational path runs from out_ready back to in_ready.
module pipe_skid_reg #(
  parameter int WIDTH          = 32,
  parameter int NUM_STALL      = 3,
  parameter bit CLEAR_ON_FLUSH = 1'b1,
  parameter int CNT_W          = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  input  logic [NUM_STALL-1:0] stall,
  input  logic                 in_valid,
  input  logic [WIDTH-1:0]     in_data,
  output logic                 in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  input  logic                 out_ready,
  output logic [1:0]           occupancy,
  output logic [CNT_W-1:0]     flush_cnt
);

  // State encoding equals the number of held entries.
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] main;
  logic [WIDTH-1:0] skid;
  logic             stall_any;
  logic             in_fire;
  logic             out_fire;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign stall_any = |stall;
  assign in_ready  = !stall_any && (state != FULL);
  assign out_valid = (state != EMPTY);
  assign out_data  = main;
  assign occupancy = state;
  assign in_fire   = in_valid && in_ready;
  assign out_fire  = out_valid && out_ready && !stall_any;

  // Entry state machine: reset beats flush, flush beats stall and handshakes.
  // A stall needs no explicit branch: both fire terms are already low.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= EMPTY;
      main  <= '0;
      skid  <= '0;
    end else if (flush) begin
      state <= EMPTY;
      if (CLEAR_ON_FLUSH) begin
        main <= '0;
        skid <= '0;
      end
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state <= ONE;
            main  <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main <= in_data;
          end else if (in_fire) begin
            state <= FULL;
            skid  <= in_data;
          end else if (out_fire) begin
            state <= EMPTY;
          end
        end
        FULL: begin
          if (out_fire) begin
            state <= ONE;
            main  <= skid;
          end
        end
        default: state <= EMPTY;
      endcase
    end
  end

  // Count flushes that actually discarded something; reset clears silently.
  always_ff @(posedge clk) begin
    if (!rst) begin
      flush_cnt <= '0;
    end else if (flush && (state != EMPTY)) begin
      flush_cnt <= sat_inc(flush_cnt);
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Directed and randomised stimulus for pipe_skid_reg with a queue scoreboard.
// Instance dut uses CLEAR_ON_FLUSH=1 and CNT_W=2; instance dut_b shares all
// inputs but keeps its data on flush.
module tb_pipe_skid_reg;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        flush = 1'b0;
  logic [2:0]  stall = 3'b000;
  logic        in_valid = 1'b0;
  logic [31:0] in_data = '0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] out_data;
  logic [1:0]  occupancy;
  logic [1:0]  flush_cnt;
  logic        in_ready_b, out_valid_b;
  logic [31:0] out_data_b;
  logic [1:0]  occupancy_b;
  logic [7:0]  flush_cnt_b;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] q[$];
  logic [1:0]  m_cnt;
  logic [31:0] m_main;
  logic [31:0] m_main_b;

  always #5 clk = ~clk;

  pipe_skid_reg #(.WIDTH(32), .NUM_STALL(3), .CLEAR_ON_FLUSH(1'b1), .CNT_W(2)) dut (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_data(out_data), .out_ready(out_ready),
    .occupancy(occupancy), .flush_cnt(flush_cnt)
  );

  pipe_skid_reg #(.WIDTH(32), .NUM_STALL(3), .CLEAR_ON_FLUSH(1'b0), .CNT_W(8)) dut_b (
    .clk(clk), .rst(rst), .flush(flush), .stall(stall),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready_b),
    .out_valid(out_valid_b), .out_data(out_data_b), .out_ready(out_ready),
    .occupancy(occupancy_b), .flush_cnt(flush_cnt_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check pre-edge outputs against the model,
  // then advance the model across the edge.
  task automatic cyc(input logic r, input logic fl, input logic [2:0] st,
                     input logic iv, input logic [31:0] d, input logic ordy);
    logic sa, inf, outf;
    rst = r; flush = fl; stall = st; in_valid = iv; in_data = d; out_ready = ordy;
    #1;
    sa = |st;
    chk("in_ready", {31'd0, in_ready}, {31'd0, (!sa && q.size() < 2)});
    chk("out_valid", {31'd0, out_valid}, {31'd0, (q.size() != 0)});
    chk("occupancy", {30'd0, occupancy}, 32'(q.size()));
    chk("flush_cnt", {30'd0, flush_cnt}, {30'd0, m_cnt});
    chk("out_data", out_data, m_main);
    chk("out_data_b", out_data_b, m_main_b);
    inf  = iv && !sa && (q.size() < 2);
    outf = (q.size() != 0) && ordy && !sa;
    @(posedge clk);
    if (!r) begin
      q.delete();
      m_cnt = 2'd0; m_main = '0; m_main_b = '0;
    end else if (fl) begin
      if (q.size() != 0 && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
      q.delete();
      m_main = '0;
    end else begin
      if (outf) void'(q.pop_front());
      if (inf) q.push_back(d);
    end
    if (q.size() != 0) begin
      m_main = q[0];
      m_main_b = q[0];
    end
    #1;
  endtask

  initial begin
    // Initial reset, no checks while state is still unknown.
    @(posedge clk); #1;
    q.delete(); m_cnt = 2'd0; m_main = '0; m_main_b = '0;

    // Held in reset: in_ready follows stall only.
    cyc(1'b0, 1'b0, 3'b001, 1'b1, 32'h99, 1'b1);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 32'h99, 1'b1);

    // Streaming 1..4 with out_ready high, then drain.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'(i), 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);

    // Backpressure: A,B fill both registers, C is refused.
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'hA, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'hB, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'hC, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);

    // Stall while full: nothing moves for three cycles, then A, B in order.
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'hA1, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'hB2, 1'b0);
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, 3'b010, 1'b1, 32'hEE, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);

    // Flush + stall + incoming entry while full, then flush while empty.
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'h1111, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'h2222, 1'b0);
    cyc(1'b1, 1'b1, 3'b100, 1'b1, 32'h5555, 1'b1);
    cyc(1'b1, 1'b1, 3'b000, 1'b0, 32'h0, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);

    // Saturation of the 2-bit counter after a fresh reset.
    cyc(1'b0, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'h300 + 32'(i), 1'b0);
      cyc(1'b1, 1'b1, 3'b000, 1'b0, 32'h0, 1'b0);
    end
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);

    // Reset while full.
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'h77, 1'b0);
    cyc(1'b1, 1'b0, 3'b000, 1'b1, 32'h88, 1'b0);
    cyc(1'b0, 1'b0, 3'b000, 1'b1, 32'h99, 1'b1);
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b0);

    // Randomised traffic with occasional stall, flush and reset.
    for (int i = 0; i < 300; i++) begin
      cyc(($urandom_range(0, 59) != 0),
          ($urandom_range(0, 14) == 0),
          ($urandom_range(0, 4) == 0) ? 3'($urandom_range(1, 7)) : 3'b000,
          1'($urandom_range(0, 1)),
          $urandom,
          ($urandom_range(0, 3) != 0));
    end
    cyc(1'b1, 1'b0, 3'b000, 1'b0, 32'h0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
